// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: display scanout, game logic and a background
// clear engine share one RAM port; read data returns one cycle after the grant.
module framebuffer_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 3,
  parameter int PIXELS       = 76800,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ready,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              lg_req,
  input  logic              lg_we,
  input  logic [ADDR_W-1:0] lg_addr,
  input  logic [DATA_W-1:0] lg_wdata,
  output logic              lg_grant,
  output logic              lg_rvalid,
  output logic [DATA_W-1:0] lg_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enabled,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
);

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  localparam logic [1:0] TAG_NONE  = 2'd0;
  localparam logic [1:0] TAG_DISP  = 2'd1;
  localparam logic [1:0] TAG_LOGIC = 2'd2;

  clr_state_e        clr_state_q, clr_state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_val_q, clr_val_d;
  logic              clr_done_q, clr_done_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [1:0]        tag_q, tag_d;

  logic lg_forced, disp_gnt, lg_gnt, clr_gnt;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    lg_forced = lg_req && (starve_cnt_q == 8'(STARVE_LIMIT));
    disp_gnt  = !reset && disp_req && !lg_forced;
    lg_gnt    = !reset && lg_req && (lg_forced || !disp_req);
    clr_gnt   = !reset && (clr_state_q == CLR_RUN) && !disp_req && !lg_req;
  end

  always_comb begin
    ram_address       = '0;
    ram_write_enabled = 1'b0;
    ram_write_data    = '0;
    if (lg_gnt) begin
      ram_address       = lg_addr;
      ram_write_enabled = lg_we;
      ram_write_data    = lg_we ? lg_wdata : '0;
    end else if (disp_gnt) begin
      ram_address = disp_addr;
    end else if (clr_gnt) begin
      ram_address       = clr_addr_q;
      ram_write_enabled = 1'b1;
      ram_write_data    = clr_val_q;
    end
  end

  always_comb begin
    starve_cnt_d = 8'd0;
    if (lg_req && !lg_gnt)
      starve_cnt_d = (starve_cnt_q == 8'(STARVE_LIMIT)) ? starve_cnt_q : starve_cnt_q + 8'd1;
    tag_d = TAG_NONE;
    if (disp_gnt)
      tag_d = TAG_DISP;
    else if (lg_gnt && !lg_we)
      tag_d = TAG_LOGIC;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 8'd0;
      tag_q        <= TAG_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
    end
  end

  // Clear engine: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_state_q <= CLR_IDLE;
      clr_addr_q  <= '0;
      clr_val_q   <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
      clr_val_q   <= clr_val_d;
      clr_done_q  <= clr_done_d;
    end
  end

  // Clear engine: next state; a start during RUN (including the final write) is ignored
  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    clr_val_d   = clr_val_q;
    clr_done_d  = 1'b0;
    case (clr_state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_d = CLR_RUN;
          clr_addr_d  = '0;
          clr_val_d   = clr_value;
        end
      end
      CLR_RUN: begin
        if (clr_gnt) begin
          if (clr_addr_q == ADDR_W'(PIXELS - 1)) begin
            clr_state_d = CLR_IDLE;
            clr_done_d  = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
      end
      default: clr_state_d = CLR_IDLE;
    endcase
  end

  // Clear engine and read-return outputs
  always_comb begin
    clr_busy    = (clr_state_q == CLR_RUN);
    clr_done    = clr_done_q;
    disp_ready  = disp_gnt;
    lg_grant    = lg_gnt;
    disp_rvalid = (tag_q == TAG_DISP);
    lg_rvalid   = (tag_q == TAG_LOGIC);
    disp_rdata  = disp_rvalid ? ram_read_data : '0;
    lg_rdata    = lg_rvalid ? ram_read_data : '0;
  end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port 320x240, 3-bit framebuffer RAM among three requesters: the VGA scanout reader, the game-logic read/write port, and an internal background clear engine. It sits between those clients and the RAM's single address/write-enable/data interface. Each cycle it grants at most one access, routes the 1-cycle-latency read data back to the client that issued the read, and guarantees bounded latency for game logic under continuous scanout.

## Interface
Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 3, pixel width.
- PIXELS, 76800, number of framebuffer words the clear engine writes (320*240).
- STARVE_LIMIT, 8, consecutive denied logic cycles before logic is forced ahead of display (1..255).

Ports (clock and reset first):
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high.
- disp_req  in  1  scanout read request.
- disp_addr  in  ADDR_W  scanout read address.
- disp_ready  out  1  display access granted this cycle (combinational).
- disp_rvalid  out  1  disp_rdata valid.
- disp_rdata  out  DATA_W  read data; 0 when disp_rvalid=0.
- lg_req  in  1  game-logic access request.
- lg_we  in  1  1 = write, 0 = read.
- lg_addr  in  ADDR_W  game-logic address.
- lg_wdata  in  DATA_W  game-logic write data.
- lg_grant  out  1  logic access granted this cycle (combinational).
- lg_rvalid  out  1  lg_rdata valid.
- lg_rdata  out  DATA_W  read data; 0 when lg_rvalid=0.
- clr_start  in  1  start full-buffer clear (one-cycle pulse).
- clr_value  in  DATA_W  fill value, sampled on accepted clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.
- ram_address  out  ADDR_W  RAM address.
- ram_write_enabled  out  1  RAM write strobe.
- ram_write_data  out  DATA_W  RAM write data.
- ram_read_data  in  DATA_W  RAM read data, valid one cycle after address.

## Operation
- Per-cycle owner is selected combinationally, in priority order:
  1. LOGIC_FORCED: lg_req && starve_cnt==STARVE_LIMIT.
  2. DISPLAY: disp_req.
  3. LOGIC: lg_req.
  4. CLEAR: clr_busy.
  5. IDLE.
- Outputs by owner:
  - DISPLAY: ram_address=disp_addr, ram_write_enabled=0.
  - LOGIC and LOGIC_FORCED: ram_address=lg_addr, ram_write_enabled=lg_we, ram_write_data=lg_wdata.
  - CLEAR: ram_address=clr_addr, ram_write_enabled=1, ram_write_data=clr_val.
  - IDLE: all three RAM outputs are 0.
- ram_write_data is 0 whenever ram_write_enabled=0.
- starve_cnt (8 bits):
  - increments when lg_req && !lg_grant, saturating at STARVE_LIMIT;
  - clears to 0 when lg_grant is high or lg_req is low.
- Read tag register, 2 bits {NONE, DISP, LOGIC}:
  - set to DISP on a display grant;
  - set to LOGIC on a logic grant with lg_we=0;
  - set to NONE otherwise.
  - disp_rvalid = (tag==DISP); lg_rvalid = (tag==LOGIC). The matching rdata is ram_read_data, and 0 otherwise.
- Clear engine (states IDLE, RUN):
  - clr_start in IDLE latches clr_val=clr_value, sets clr_addr=0, and enters RUN.
  - In RUN, each CLEAR-granted cycle writes clr_val at clr_addr and then increments clr_addr.
  - The grant that writes address PIXELS-1 returns the engine to IDLE and pulses clr_done on the next cycle.
  - clr_start while in RUN is ignored; the latched value is unchanged.
- Clear writes race with logic writes. Logic writes to already-cleared addresses persist. Game logic must not write during a clear it depends on.

## Timing
- Reset values: starve_cnt=0, tag=NONE, clear engine IDLE, clr_addr=0, clr_val=0, clr_busy=0, clr_done=0. Consequently every output is 0 while reset is asserted.
- Grant latency is 0 cycles: grant signals and RAM outputs are combinational in the request cycle.
- Read latency is exactly 1 cycle from grant to rvalid. Back-to-back reads give back-to-back rvalid.
- Writes produce no rvalid.
- Worst-case logic wait under continuous disp_req is STARVE_LIMIT denied cycles; the grant comes on cycle STARVE_LIMIT+1 of the request.
- A forced logic grant drops disp_ready for that cycle. The display client holds disp_addr and retries.
- clr_busy rises the cycle after an accepted clr_start. With no competing requests it stays high for exactly PIXELS cycles; clr_done is high in the first cycle busy is low.
- clr_start asserted in the same cycle as completion: the completion cycle is still in RUN, so the start is ignored.
- Reset mid-clear aborts immediately, with no clr_done pulse. An in-flight read's rvalid is dropped.

## Test plan
- Idle bus, lg_req=1, lg_we=1, lg_addr=38420, lg_wdata=3'b100 -> lg_grant=1 same cycle, ram_write_enabled=1, ram_address=38420, ram_write_data=3'b100, no lg_rvalid.
- disp_req and lg_req (read) both held continuously with STARVE_LIMIT=8 -> disp_ready on cycles 1-8, lg_grant on cycle 9 with disp_ready=0, lg_rvalid on cycle 10 carrying the RAM word at lg_addr; pattern repeats every 9 cycles.
- Alternating display reads at addresses 0,1,2 and logic read at 100 -> each rvalid fires exactly one cycle after its grant and only on the issuing client; the other client's rdata reads 0.
- clr_start with clr_value=3'b000 and no other requests -> clr_busy high for 76800 cycles, ram addresses 0..76799 written with 0, clr_done single pulse; a second clr_start mid-run is ignored.
- Clear running while disp_req toggles every other cycle -> clear writes only occur on non-display cycles; completion is delayed by exactly the number of display grants.
- Assert reset at clear address 5000 -> all outputs 0 immediately; after release clr_busy=0, no clr_done pulse, and the next clr_start restarts at address 0.
